// File: rtl/blk_mem_if.sv
// Port bundle for blk_mem: enable, write enable, shared address, write data and read data.
interface blk_mem_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  ena;
    logic                  wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic [DATA_WIDTH-1:0] douta;

    modport master (output ena, wea, addra, dina, input douta);
    modport slave  (input ena, wea, addra, dina, output douta);
endinterface

// File: rtl/blk_mem.sv
// Single-port synchronous block RAM with registered read data, selectable
// write-cycle output behaviour and an optional second output register.
module blk_mem #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 4,
    parameter int                    READ_LATENCY = 1,
    parameter string                 WRITE_MODE   = "WRITE_FIRST",
    parameter logic [DATA_WIDTH-1:0] RST_VALUE    = '0
) (
    input  logic      clka,
    input  logic      rsta,
    blk_mem_if.slave  bus
);
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam bit MODE_WF = (WRITE_MODE == "WRITE_FIRST");
    localparam bit MODE_RF = (WRITE_MODE == "READ_FIRST");

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] s1_q = RST_VALUE;

    // A write in a reset cycle is dropped so reset never disturbs contents.
    always_ff @(posedge clka) begin
        if (!rsta && bus.ena && bus.wea) begin
            mem[bus.addra] <= bus.dina;
        end
    end

    // READ_FIRST reads mem here before the write above lands, giving the old word.
    always_ff @(posedge clka) begin
        if (rsta) begin
            s1_q <= RST_VALUE;
        end else if (bus.ena) begin
            if (!bus.wea) begin
                s1_q <= mem[bus.addra];
            end else if (MODE_WF) begin
                s1_q <= bus.dina;
            end else if (MODE_RF) begin
                s1_q <= mem[bus.addra];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_q = RST_VALUE;

            always_ff @(posedge clka) begin
                if (rsta) begin
                    s2_q <= RST_VALUE;
                end else if (bus.ena) begin
                    s2_q <= s1_q;
                end
            end

            assign bus.douta = s2_q;
        end else begin : g_lat1
            assign bus.douta = s1_q;
        end
    endgenerate
endmodule

// File: tb/tb_blk_mem.sv
// Scoreboard bench: four blk_mem variants (WRITE_FIRST, READ_FIRST, NO_CHANGE at
// latency 1, WRITE_FIRST at latency 2) share one directed stimulus stream.
module tb_blk_mem;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic       wea = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] din = '0;
    logic [7:0] o [4];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vid   = 0;

    typedef struct packed {
        int          due;
        int          tag;
        logic [3:0]  m;
        logic [31:0] e;
    } sb_t;

    sb_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    blk_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
    blk_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();
    blk_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if2 ();
    blk_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if3 ();

    assign if0.ena = ena;  assign if0.wea = wea;  assign if0.addra = addr;  assign if0.dina = din;
    assign if1.ena = ena;  assign if1.wea = wea;  assign if1.addra = addr;  assign if1.dina = din;
    assign if2.ena = ena;  assign if2.wea = wea;  assign if2.addra = addr;  assign if2.dina = din;
    assign if3.ena = ena;  assign if3.wea = wea;  assign if3.addra = addr;  assign if3.dina = din;
    assign o[0] = if0.douta;
    assign o[1] = if1.douta;
    assign o[2] = if2.douta;
    assign o[3] = if3.douta;

    blk_mem #(.READ_LATENCY(1), .WRITE_MODE("WRITE_FIRST")) dut_wf (.clka(clk), .rsta(rst), .bus(if0));
    blk_mem #(.READ_LATENCY(1), .WRITE_MODE("READ_FIRST"))  dut_rf (.clka(clk), .rsta(rst), .bus(if1));
    blk_mem #(.READ_LATENCY(1), .WRITE_MODE("NO_CHANGE"))   dut_nc (.clka(clk), .rsta(rst), .bus(if2));
    blk_mem #(.READ_LATENCY(2), .WRITE_MODE("WRITE_FIRST")) dut_l2 (.clka(clk), .rsta(rst), .bus(if3));

    // Monitor: one entry is due per cycle; compare every masked output.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            sb_t t;
            logic [7:0] x;
            t = q.pop_front();
            for (int d = 0; d < 4; d++) begin
                if (t.m[d]) begin
                    x = t.e[d*8 +: 8];
                    total++;
                    if (o[d] !== x) begin
                        bad++;
                        $display("FAIL vec%0d dut%0d douta got=%h exp=%h", t.tag, d, o[d], x);
                    end
                end
            end
        end
    end

    // Apply one vector for one edge; expectations are douta after that edge
    // for dut_wf, dut_rf, dut_nc, dut_l2 respectively.
    task automatic vec(input logic r, input logic e, input logic w,
                       input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] x0, input logic [7:0] x1,
                       input logic [7:0] x2, input logic [7:0] x3,
                       input logic [3:0] m);
        sb_t t;
        vid++;
        t.due = cyc + 1;
        t.tag = vid;
        t.m   = m;
        t.e   = {x3, x2, x1, x0};
        q.push_back(t);
        rst  = r;
        ena  = e;
        wea  = w;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] rf_old;
        logic [7:0] l2_prev;

        #1;
        for (int d = 0; d < 4; d++) begin
            total++;
            if (o[d] !== 8'h00) begin
                bad++;
                $display("FAIL powerup dut%0d douta got=%h exp=00", d, o[d]);
            end
        end

        // reset, including with ena low
        vec(1, 0, 0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
        vec(1, 1, 0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);

        // write 0,1,2 to addr 0,1,2, each held two cycles
        vec(0, 1, 1, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
        vec(0, 1, 1, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
        vec(0, 1, 1, 4'd1, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 4'hF);
        vec(0, 1, 1, 4'd1, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 4'hF);
        vec(0, 1, 1, 4'd2, 8'h02, 8'h02, 8'h00, 8'h00, 8'h01, 4'hF);
        vec(0, 1, 1, 4'd2, 8'h02, 8'h02, 8'h02, 8'h00, 8'h02, 4'hF);

        // streamed reads 0,1,2; latency-2 output trails by one edge
        vec(0, 1, 0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 4'hF);
        vec(0, 1, 0, 4'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 4'hF);
        vec(0, 1, 0, 4'd2, 8'h00, 8'h02, 8'h02, 8'h02, 8'h01, 4'hF);
        vec(0, 1, 0, 4'd2, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 4'hF);

        // write modes on addr 5: preload A5, read other word, overwrite with 3C
        vec(0, 1, 1, 4'd5, 8'hA5, 8'hA5, 8'h00, 8'h02, 8'h02, 4'hF);
        vec(0, 1, 0, 4'd5, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 4'hF);
        vec(0, 1, 0, 4'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'hA5, 4'hF);
        vec(0, 1, 1, 4'd5, 8'h3C, 8'h3C, 8'hA5, 8'h01, 8'h01, 4'hF);
        vec(0, 1, 0, 4'd5, 8'h00, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 4'hF);

        // enable gating: both pipeline stages of dut_l2 differ before the freeze
        vec(0, 1, 0, 4'd2, 8'h00, 8'h02, 8'h02, 8'h02, 8'h3C, 4'hF);
        vec(0, 0, 1, 4'd3, 8'hFF, 8'h02, 8'h02, 8'h02, 8'h3C, 4'hF);
        vec(0, 0, 1, 4'd3, 8'hFF, 8'h02, 8'h02, 8'h02, 8'h3C, 4'hF);
        vec(0, 1, 0, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 4'hF);
        vec(0, 1, 0, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);

        // reset with a write pending: output cleared, contents kept
        vec(0, 1, 0, 4'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 4'hF);
        vec(0, 1, 0, 4'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 4'hF);
        vec(1, 1, 1, 4'd1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
        vec(1, 1, 1, 4'd1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
        vec(0, 1, 0, 4'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 4'hF);
        vec(0, 1, 0, 4'd1, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 4'hF);

        // full range: write i^5A everywhere
        for (int i = 0; i < 16; i++) begin
            v = 8'(i) ^ 8'h5A;
            case (i)
                1:       rf_old = 8'h01;
                2:       rf_old = 8'h02;
                5:       rf_old = 8'h3C;
                default: rf_old = 8'h00;
            endcase
            l2_prev = (i == 0) ? 8'h01 : (8'(i - 1) ^ 8'h5A);
            vec(0, 1, 1, 4'(i), v, v, rf_old, 8'h01, l2_prev, 4'hF);
        end

        // read back all 16, then one extra edge to drain the latency-2 output
        for (int i = 0; i < 16; i++) begin
            v = 8'(i) ^ 8'h5A;
            l2_prev = (i == 0) ? (8'h0F ^ 8'h5A) : (8'(i - 1) ^ 8'h5A);
            vec(0, 1, 0, 4'(i), 8'h00, v, v, v, l2_prev, 4'hF);
        end
        vec(0, 1, 0, 4'd15, 8'h00, 8'h55, 8'h55, 8'h55, 8'h55, 4'hF);

        ena = 1'b0;
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain queue left=%0d exp=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
